// File: rtl/ysyx_22040125_dmem_ctrl_if.sv
// Request/response bundle between the LSU (master) and the data memory controller (slave).
interface ysyx_22040125_dmem_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22040125_dmem_ctrl.sv
// Data memory with valid/ready request/response, byte-lane stores and programmable read latency.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned accesses fault instead of being aligned down.
module ysyx_22040125_dmem_ctrl #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32,
    parameter int LAT    = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    ysyx_22040125_dmem_ctrl_if.slave bus
);
    localparam int NB     = DATA_W / 8;
    localparam int OFF    = $clog2(NB);
    localparam int IDX_W  = ADDR_W - OFF;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [IDX_W:0] DEPTH_X = DEPTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic [3:0]        cnt;
    logic              err_q;
    logic              wen_q;
    logic [1:0]        size_q;
    logic [OFF-1:0]    off_q;
    logic [DATA_W-1:0] rd_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [MEM_AW-1:0] midx;
    logic [OFF-1:0]    off_raw;
    logic [OFF-1:0]    off_eff;
    logic [OFF-1:0]    size_mask;
    logic [3:0]        nbytes;
    logic [3:0]        nbytes_q;
    logic              range_err;
    logic              size_err;
    logic              misalign;
    logic              req_err;
    logic              accept;
    logic              do_write;
    logic [NB-1:0]     wstrb;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rdata;

    assign idx       = bus.req_addr[ADDR_W-1:OFF];
    assign midx      = idx[MEM_AW-1:0];
    assign off_raw   = bus.req_addr[OFF-1:0];
    assign nbytes    = 4'd1 << bus.req_size;
    assign size_mask = OFF'(nbytes - 4'd1);
    assign misalign  = |(off_raw & size_mask);
    assign range_err = {1'b0, idx} >= DEPTH_X;
    assign size_err  = (bus.req_size == 2'd3) && (DATA_W == 32);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign off_eff = off_raw;
    assign req_err = range_err | size_err | misalign;
`else
    assign off_eff = off_raw & ~size_mask;
    assign req_err = range_err | size_err;
`endif

    assign accept   = bus.req_valid && (state == IDLE);
    assign do_write = accept && bus.req_wen && !req_err;
    // The shift-then-subtract wraps to all ones when a full-word strobe overflows NB bits.
    assign wstrb    = ((NB'(1) << nbytes) - NB'(1)) << off_eff;
    assign wdata_sh = bus.req_wdata << {off_eff, 3'b000};

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[midx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 4'd0;
            err_q  <= 1'b0;
            wen_q  <= 1'b0;
            size_q <= 2'd0;
            off_q  <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            cnt    <= (LAT > 1) ? 4'(LAT - 1) : 4'd0;
            err_q  <= req_err;
            wen_q  <= bus.req_wen;
            size_q <= bus.req_size;
            off_q  <= off_eff;
            rd_q   <= mem[midx];
        end else if (state == WAIT) begin
            cnt    <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid) state_nxt = (LAT == 1) ? RESP : WAIT;
            WAIT: if (cnt <= 4'd1) state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign nbytes_q = 4'd1 << size_q;
    assign rd_shift = rd_q >> {off_q, 3'b000};

    always_comb begin
        rdata = '0;
        if (state == RESP && !wen_q && !err_q) begin
            for (int b = 0; b < NB; b++) begin
                if (b < int'(nbytes_q)) begin
                    rdata[8*b +: 8] = rd_shift[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_err   = (state == RESP) && err_q;
        bus.rsp_rdata = rdata;
    end
endmodule

// File: tb/tb_ysyx_22040125_dmem_ctrl.sv
// Scoreboard bench for ysyx_22040125_dmem_ctrl: one instance with LAT=1, one with LAT=4,
// checked against a byte-level reference memory.
module tb_ysyx_22040125_dmem_ctrl;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam int NBYTES = DEPTH * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n;
    logic        rst4_n;
    logic        sel;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        rsp_ready;

    ysyx_22040125_dmem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
    ysyx_22040125_dmem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus4 ();

    assign bus1.req_valid = req_valid & ~sel;
    assign bus4.req_valid = req_valid & sel;
    assign bus1.rsp_ready = rsp_ready & ~sel;
    assign bus4.rsp_ready = rsp_ready & sel;
    assign bus1.req_wen   = req_wen;
    assign bus4.req_wen   = req_wen;
    assign bus1.req_addr  = req_addr;
    assign bus4.req_addr  = req_addr;
    assign bus1.req_size  = req_size;
    assign bus4.req_size  = req_size;
    assign bus1.req_wdata = req_wdata;
    assign bus4.req_wdata = req_wdata;

    wire        mon_req_ready = sel ? bus4.req_ready : bus1.req_ready;
    wire        mon_rsp_valid = sel ? bus4.rsp_valid : bus1.rsp_valid;
    wire [63:0] mon_rsp_rdata = sel ? bus4.rsp_rdata : bus1.rsp_rdata;
    wire        mon_rsp_err   = sel ? bus4.rsp_err   : bus1.rsp_err;

    ysyx_22040125_dmem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1.slave)
    );

    ysyx_22040125_dmem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (bus4.slave)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [2][NBYTES];
    int         nchk  = 0;
    int         nfail = 0;

    function automatic logic model_err(logic [31:0] addr, logic [1:0] size);
        logic e;
        e = (addr >> 3) >= DEPTH;
`ifdef DMEM_MISALIGN_CHECK_EN
        e = e || ((addr & ((32'd1 << size) - 32'd1)) != 32'd0);
`endif
        return e;
    endfunction

    function automatic logic [31:0] model_base(logic [31:0] addr, logic [1:0] size);
`ifdef DMEM_MISALIGN_CHECK_EN
        return addr;
`else
        return addr & ~((32'd1 << size) - 32'd1);
`endif
    endfunction

    // Expected response is computed before the store is folded into the model (read-before-write).
    function automatic void push_exp(int d, bit wen, logic [31:0] addr, logic [1:0] size, logic [63:0] wdata);
        exp_t        e;
        logic [31:0] base;
        e.err   = model_err(addr, size);
        e.lat   = (d != 0) ? 4 : 1;
        e.rdata = '0;
        base    = model_base(addr, size);
        if (!e.err) begin
            for (int b = 0; b < (1 << size); b++) begin
                if (wen) model[d][base + b] = wdata[8*b +: 8];
                else     e.rdata[8*b +: 8]  = model[d][base + b];
            end
        end
        sb.push_back(e);
    endfunction

    task automatic drive_req(input int d, input bit wen, input logic [31:0] addr, input logic [1:0] size,
                             input logic [63:0] wdata, output logic [63:0] rdata, output logic err, output int lat);
        int w;
        push_exp(d, wen, addr, size, wdata);
        @(negedge clk);
        sel       = (d != 0);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        w = 0;
        while (!mon_req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!mon_req_ready) begin
            nchk++; nfail++;
            $display("[TB] FAIL req_ready_timeout: req_ready=%0b, required 1", mon_req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!mon_rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!mon_rsp_valid) begin
            nchk++; nfail++;
            $display("[TB] FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", mon_rsp_valid, lat);
        end
        rdata = mon_rsp_rdata;
        err   = mon_rsp_err;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst1_n = 1'b0; rst4_n = 1'b0;
        sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nchk++; if (bus1.req_ready !== 1'b1) begin nfail++; $display("[TB] FAIL rst_req_ready1: got %0b, required 1", bus1.req_ready); end
        nchk++; if (bus1.rsp_valid !== 1'b0) begin nfail++; $display("[TB] FAIL rst_rsp_valid1: got %0b, required 0", bus1.rsp_valid); end
        nchk++; if (bus1.rsp_err !== 1'b0) begin nfail++; $display("[TB] FAIL rst_rsp_err1: got %0b, required 0", bus1.rsp_err); end
        nchk++; if (bus1.rsp_rdata !== 64'd0) begin nfail++; $display("[TB] FAIL rst_rdata1: got %h, required 0", bus1.rsp_rdata); end
        nchk++; if (bus4.req_ready !== 1'b1) begin nfail++; $display("[TB] FAIL rst_req_ready4: got %0b, required 1", bus4.req_ready); end
        nchk++; if (bus4.rsp_valid !== 1'b0) begin nfail++; $display("[TB] FAIL rst_rsp_valid4: got %0b, required 0", bus4.rsp_valid); end
        nchk++; if (bus4.rsp_err !== 1'b0) begin nfail++; $display("[TB] FAIL rst_rsp_err4: got %0b, required 0", bus4.rsp_err); end
        @(negedge clk);
        rst1_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [63:0] rd; logic er; int lat; exp_t e;
        drive_req(0, 1'b1, 32'h10, 2'd3, 64'h1122334455667788, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL sd_10: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        finish_rsp();
        drive_req(0, 1'b0, 32'h10, 2'd3, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL ld_10: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        nchk++; if (rd !== 64'h1122334455667788) begin nfail++; $display("[TB] FAIL ld_10_value: got %h, required 1122334455667788", rd); end
        nchk++; if (lat !== e.lat) begin nfail++; $display("[TB] FAIL ld_10_latency: got %0d, required %0d", lat, e.lat); end
        finish_rsp();
    endtask

    task automatic test_subword();
        logic [63:0] rd; logic er; int lat; exp_t e;
        drive_req(0, 1'b1, 32'h13, 2'd0, 64'hAA, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL sb_13: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        finish_rsp();
        drive_req(0, 1'b0, 32'h10, 2'd2, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL lw_10: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        finish_rsp();
        drive_req(0, 1'b0, 32'h16, 2'd1, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL lh_16: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        nchk++; if (rd !== 64'h1122) begin nfail++; $display("[TB] FAIL lh_16_value: got %h, required 1122", rd); end
        finish_rsp();
    endtask

    task automatic test_latency_backpressure();
        logic [63:0] rd; logic er; int lat; exp_t e;
        drive_req(1, 1'b1, 32'h40, 2'd3, 64'h0123456789ABCDEF, rd, er, lat);
        e = sb.pop_front();
        nchk++; if (lat !== 4) begin nfail++; $display("[TB] FAIL sd_40_latency: got %0d, required 4", lat); end
        finish_rsp();
        drive_req(1, 1'b0, 32'h40, 2'd3, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL ld_40: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        nchk++; if (lat !== e.lat) begin nfail++; $display("[TB] FAIL ld_40_latency: got %0d, required %0d", lat, e.lat); end
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h40; req_size = 2'd3; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            nchk++;
            if (bus4.rsp_valid !== 1'b1 || bus4.rsp_rdata !== e.rdata || bus4.req_ready !== 1'b0) begin
                nfail++;
                $display("[TB] FAIL hold_%0d: got valid=%0b rdata=%h ready=%0b, required valid=1 rdata=%h ready=0",
                         i, bus4.rsp_valid, bus4.rsp_rdata, bus4.req_ready, e.rdata);
            end
        end
        req_valid = 1'b0;
        finish_rsp();
        drive_req(1, 1'b0, 32'h40, 2'd3, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL ignored_req: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        finish_rsp();
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic er; int lat; exp_t e;
        drive_req(0, 1'b0, NBYTES, 2'd3, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if (er !== 1'b1 || rd !== 64'd0) begin nfail++; $display("[TB] FAIL range_err1: got err=%0b rdata=%h, required err=1 rdata=0", er, rd); end
        finish_rsp();
        drive_req(1, 1'b0, NBYTES + 8, 2'd3, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if (er !== 1'b1 || rd !== 64'd0 || lat !== e.lat) begin nfail++; $display("[TB] FAIL range_err4: got err=%0b rdata=%h lat=%0d, required err=1 rdata=0 lat=%0d", er, rd, lat, e.lat); end
        finish_rsp();
        drive_req(0, 1'b1, 32'h12, 2'd2, 64'hDEADBEEF, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL sw_12: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        finish_rsp();
        drive_req(0, 1'b0, 32'h10, 2'd3, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata}) begin nfail++; $display("[TB] FAIL ld_after_sw_12: got err=%0b rdata=%h, required err=%0b rdata=%h", er, rd, e.err, e.rdata); end
        finish_rsp();
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] rd; logic er; int lat; int seen; exp_t e;
        push_exp(1, 1'b1, 32'h20, 2'd3, 64'h55);
        void'(sb.pop_back());
        @(negedge clk);
        sel = 1'b1; req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h20; req_size = 2'd3; req_wdata = 64'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst4_n = 1'b0;
        #1;
        nchk++; if (bus4.rsp_valid !== 1'b0 || bus4.req_ready !== 1'b1) begin nfail++; $display("[TB] FAIL mid_reset: got valid=%0b ready=%0b, required valid=0 ready=1", bus4.rsp_valid, bus4.req_ready); end
        repeat (2) @(negedge clk);
        rst4_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus4.rsp_valid) seen++;
        end
        nchk++; if (seen !== 0) begin nfail++; $display("[TB] FAIL dropped_rsp: got %0d response cycles, required 0", seen); end
        drive_req(1, 1'b0, 32'h20, 2'd3, 64'd0, rd, er, lat);
        e = sb.pop_front();
        nchk++; if ({er, rd} !== {e.err, e.rdata} || rd !== 64'h55) begin nfail++; $display("[TB] FAIL ld_20_after_reset: got err=%0b rdata=%h, required err=0 rdata=%h", er, rd, e.rdata); end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd; logic er; int lat; exp_t e;
        logic [31:0] addr; logic [1:0] size; logic [63:0] wd; bit wen;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) begin
                wen = 1'b1; addr = 32'h80 + 32'(8 * i); size = 2'd3;
            end else begin
                wen = 1'($urandom_range(0, 1)); addr = 32'h80 + 32'($urandom_range(0, 63)); size = 2'($urandom_range(0, 3));
            end
            wd = {$urandom, $urandom};
            drive_req(0, wen, addr, size, wd, rd, er, lat);
            e = sb.pop_front();
            nchk++;
            if ({er, rd} !== {e.err, e.rdata} || lat !== e.lat) begin
                nfail++;
                $display("[TB] FAIL b2b_%0d wen=%0b addr=%h size=%0d: got err=%0b rdata=%h lat=%0d, required err=%0b rdata=%h lat=%0d",
                         i, wen, addr, size, er, rd, lat, e.err, e.rdata, e.lat);
            end
            finish_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_latency_backpressure();
        test_errors();
        test_reset_mid_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
